// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile
// Description : Write-back sink of the pipeline. Holds the general-purpose
//               register file and the HI/LO pair. It also keeps a counter of
//               committed GPR writes.
//               Both GPR read ports and the HI/LO outputs bypass the
//               write-back data in the same cycle (write-through).
//
// Ports       : clk           clock, all state updates on the rising edge
//               rst           asynchronous active-high reset
//               wb_wreg_i     GPR write enable from the write-back stage
//               wb_wd_i       GPR write address
//               wb_wdata_i    GPR write data
//               wb_whilo_i    HI/LO pair write enable
//               wb_hi_i       HI write data
//               wb_lo_i       LO write data
//               re1_i         read port 1 enable
//               raddr1_i      read port 1 address
//               rdata1_o      read port 1 data (combinational)
//               re2_i         read port 2 enable
//               raddr2_i      read port 2 address
//               rdata2_o      read port 2 data (combinational)
//               hi_o          current HI (combinational, bypassed)
//               lo_o          current LO (combinational, bypassed)
//               wr_cnt_o      committed GPR write count (registered)
//
// Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_wreg_i,
  input  logic [ADDR_W-1:0] wb_wd_i,
  input  logic [DATA_W-1:0] wb_wdata_i,
  input  logic              wb_whilo_i,
  input  logic [DATA_W-1:0] wb_hi_i,
  input  logic [DATA_W-1:0] wb_lo_i,
  input  logic              re1_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  output logic [DATA_W-1:0] rdata1_o,
  input  logic              re2_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata2_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic [CNT_W-1:0]  wr_cnt_o
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] gpr_q [NUM_REGS];
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] hi_d;
  logic [DATA_W-1:0] lo_q;
  logic [DATA_W-1:0] lo_d;
  logic [CNT_W-1:0]  wr_cnt_q;
  logic [CNT_W-1:0]  wr_cnt_d;

  // A GPR write only commits when it targets a non-zero register; this single
  // qualifier drives both the array update and the retired-write counter.
  logic w_commit;
  assign w_commit = wb_wreg_i && (wb_wd_i != '0);

  // --------------------------------------------------------------------------
  // GPR array. Entry 0 is only ever cleared, so it stays hardwired to zero.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        gpr_q[i] <= '0;
      end
    end else if (w_commit) begin
      gpr_q[wb_wd_i] <= wb_wdata_i;
    end
  end

  // --------------------------------------------------------------------------
  // HI/LO pair and retired-write counter
  // --------------------------------------------------------------------------
  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    wr_cnt_d = wr_cnt_q;
    if (wb_whilo_i) begin
      hi_d = wb_hi_i;
      lo_d = wb_lo_i;
    end
    // Counter wraps naturally modulo 2**CNT_W.
    if (w_commit) begin
      wr_cnt_d = wr_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q     <= '0;
      lo_q     <= '0;
      wr_cnt_q <= '0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Read paths. The stored state is already zero during reset, but the bypass
  // paths come straight from the write-back inputs, so they are gated by rst
  // to keep every read at zero while reset is held.
  // --------------------------------------------------------------------------
  function automatic logic [DATA_W-1:0] f_read(
    input logic              re,
    input logic [ADDR_W-1:0] addr
  );
    logic [DATA_W-1:0] data;
    data = '0;
    if (!re || (addr == '0)) begin
      data = '0;
    end else if (wb_wreg_i && (wb_wd_i == addr)) begin
      data = wb_wdata_i;
    end else begin
      data = gpr_q[addr];
    end
    return data;
  endfunction

  always_comb begin
    rdata1_o = '0;
    rdata2_o = '0;
    hi_o     = '0;
    lo_o     = '0;
    if (!rst) begin
      rdata1_o = f_read(re1_i, raddr1_i);
      rdata2_o = f_read(re2_i, raddr2_i);
      hi_o     = wb_whilo_i ? wb_hi_i : hi_q;
      lo_o     = wb_whilo_i ? wb_lo_i : lo_q;
    end
  end

  assign wr_cnt_o = wr_cnt_q;

endmodule
`default_nettype wire
